// File: rtl/posit8_pkg.sv
// Shared posit8 (es=0) definitions used by the encoder and the decode side.
//   BIAS / EXP_MAX / FRAC_W : exponent bias, largest legal biased exponent, fraction width
//   POSIT8_* constants      : special encodings and magnitude limits
//   posit8_fields_t         : unpacked posit fields (sign, zero, nar, exp, frac, guard, sticky)
//   posit8_apply_sign       : two's-complement sign application on a 7-bit magnitude
package posit8_pkg;

   localparam logic [3:0]  BIAS    = 4'd6;
   localparam logic [3:0]  EXP_MAX = 4'd12;
   localparam int unsigned FRAC_W  = 32'd5;

   localparam logic [7:0] POSIT8_NAR    = 8'h80;
   localparam logic [7:0] POSIT8_ZERO   = 8'h00;
   localparam logic [6:0] POSIT8_MAXPOS = 7'h7F;
   localparam logic [6:0] POSIT8_MINPOS = 7'h01;

   typedef struct packed {
      logic              sign;
      logic              zero;
      logic              nar;
      logic [3:0]        exp;
      logic [FRAC_W-1:0] frac;
      logic              guard;
      logic              sticky;
   } posit8_fields_t;

   // Negative posits are the two's complement of the positive pattern.
   function automatic logic [7:0] posit8_apply_sign(input logic sign, input logic [6:0] mag);
      logic [7:0] res;
      if (sign) begin
         res = ~{1'b0, mag} + 8'd1;
      end else begin
         res = {1'b0, mag};
      end
      return res;
   endfunction

endpackage

// File: rtl/posit8_regime_encoder_if.sv
// Valid/ready bus of the posit8 regime encoder.
//   Input side : in_valid, in_ready, sign_in, zero_in, nar_in, exp_in, frac_in, guard_in, sticky_in
//   Output side: out_valid, out_ready, posit_out
//   master = upstream/downstream environment, slave = encoder
interface posit8_regime_encoder_if;
   import posit8_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              sign_in;
   logic              zero_in;
   logic              nar_in;
   logic [3:0]        exp_in;
   logic [FRAC_W-1:0] frac_in;
   logic              guard_in;
   logic              sticky_in;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        posit_out;

   modport master (
      output in_valid, sign_in, zero_in, nar_in, exp_in, frac_in, guard_in, sticky_in,
      output out_ready,
      input  in_ready, out_valid, posit_out
   );

   modport slave (
      input  in_valid, sign_in, zero_in, nar_in, exp_in, frac_in, guard_in, sticky_in,
      input  out_ready,
      output in_ready, out_valid, posit_out
   );

endinterface

// File: rtl/posit8_regime_builder.sv
// Combinational regime generator for posit8 (es=0).
//   exp_in     : biased exponent (k = exp_in - BIAS)
//   regime_pat : regime run left-aligned in 7 magnitude bits, zeros after it
//   regime_len : bits consumed by the run plus terminator (2..7)
// Out-of-range exponents produce the maxpos pattern; the encoder saturates them anyway.
module posit8_regime_builder
   import posit8_pkg::*;
(
   input  logic [3:0] exp_in,
   output logic [6:0] regime_pat,
   output logic [2:0] regime_len
);

   logic [3:0] ones_s;
   logic [3:0] zeros_s;

   // Build the run: k>=0 gives k+1 ones then 0, k<0 gives -k zeros then 1.
   always_comb begin
      ones_s     = 4'd0;
      zeros_s    = 4'd0;
      regime_pat = POSIT8_MAXPOS;
      regime_len = 3'd7;
      if (exp_in > EXP_MAX) begin
         regime_pat = POSIT8_MAXPOS;
         regime_len = 3'd7;
      end else if (exp_in >= BIAS) begin
         ones_s     = exp_in - BIAS + 4'd1;
         regime_pat = ~(7'h7F >> ones_s);
         // k=+6 fills all seven bits, so the terminator is dropped
         regime_len = (ones_s == 4'd7) ? 3'd7 : (ones_s[2:0] + 3'd1);
      end else begin
         zeros_s    = BIAS - exp_in;
         regime_pat = 7'h40 >> zeros_s;
         regime_len = zeros_s[2:0] + 3'd1;
      end
   end

endmodule

// File: rtl/posit8_regime_encoder.sv
// Two-stage pipelined posit8 (es=0) encoder: unpacked fields in, packed posit out.
//   clk, rst : clock, synchronous active-high reset
//   bus      : valid/ready input fields and valid/ready posit_out (slave modport)
// Stage 1 builds the regime and aligns the fraction behind it, extracting the
// round and sticky bits. Stage 2 applies round-to-nearest-even, saturation,
// the special values and the sign.
module posit8_regime_encoder
   import posit8_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   posit8_regime_encoder_if.slave bus
);

   posit8_fields_t in_fields_s;
   logic           s1_adv_s;
   logic           s2_adv_s;
   logic [6:0]     regime_pat_s;
   logic [2:0]     regime_len_s;
   logic [11:0]    frac_ext_s;
   logic [11:0]    aligned_s;
   logic           round_s;
   logic           sticky_s;
   logic           sat_s;

   logic           s1_valid_r;
   logic [6:0]     s1_mag_r;
   logic           s1_round_r;
   logic           s1_sticky_r;
   logic           s1_sat_r;
   logic           s1_sign_r;
   logic           s1_zero_r;
   logic           s1_nar_r;

   logic           inc_s;
   logic [7:0]     sum_s;
   logic [6:0]     mag_rnd_s;
   logic [7:0]     posit_s;

   logic           s2_valid_r;
   logic [7:0]     s2_posit_r;

   // Gather the interface inputs into the shared field record.
   always_comb begin
      in_fields_s        = '0;
      in_fields_s.sign   = bus.sign_in;
      in_fields_s.zero   = bus.zero_in;
      in_fields_s.nar    = bus.nar_in;
      in_fields_s.exp    = bus.exp_in;
      in_fields_s.frac   = bus.frac_in;
      in_fields_s.guard  = bus.guard_in;
      in_fields_s.sticky = bus.sticky_in;
   end

   // Stage advance conditions; S1 may refill in the same cycle S2 drains.
   always_comb begin
      s2_adv_s = !s2_valid_r || bus.out_ready;
      s1_adv_s = !s1_valid_r || s2_adv_s;
   end

   assign bus.in_ready  = s1_adv_s;
   assign bus.out_valid = s2_valid_r;
   assign bus.posit_out = s2_posit_r;

   posit8_regime_builder u_regime_builder (
      .exp_in     (in_fields_s.exp),
      .regime_pat (regime_pat_s),
      .regime_len (regime_len_s)
   );

   // Place the fraction right after the regime in a 12-bit window:
   // [11:5] magnitude, [4] round candidate, [3:0] sticky candidates.
   always_comb begin
      frac_ext_s = {in_fields_s.frac, 7'b0000000};
      aligned_s  = {regime_pat_s, 5'b00000} | (frac_ext_s >> regime_len_s);
      round_s    = 1'b0;
      sticky_s   = 1'b0;
      sat_s      = (in_fields_s.exp > EXP_MAX);
      if (regime_len_s <= 3'd2) begin
         // every fraction bit fits, so guard/sticky are the rounding inputs
         round_s  = in_fields_s.guard;
         sticky_s = in_fields_s.sticky;
      end else begin
         round_s  = aligned_s[4];
         sticky_s = (|aligned_s[3:0]) | in_fields_s.guard | in_fields_s.sticky;
      end
   end

   // Stage 1 register: aligned magnitude plus rounding and special-case flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_mag_r    <= 7'h00;
         s1_round_r  <= 1'b0;
         s1_sticky_r <= 1'b0;
         s1_sat_r    <= 1'b0;
         s1_sign_r   <= 1'b0;
         s1_zero_r   <= 1'b0;
         s1_nar_r    <= 1'b0;
      end else if (s1_adv_s) begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mag_r    <= aligned_s[11:5];
            s1_round_r  <= round_s;
            s1_sticky_r <= sticky_s;
            s1_sat_r    <= sat_s;
            s1_sign_r   <= in_fields_s.sign;
            s1_zero_r   <= in_fields_s.zero;
            s1_nar_r    <= in_fields_s.nar;
         end
      end
   end

   // Round to nearest even, clamp into [minpos, maxpos], then resolve specials and sign.
   always_comb begin
      inc_s     = s1_round_r && (s1_mag_r[0] || s1_sticky_r);
      sum_s     = {1'b0, s1_mag_r} + {7'b0000000, inc_s};
      mag_rnd_s = sum_s[6:0];
      posit_s   = POSIT8_ZERO;
      if (s1_sat_r || sum_s[7]) begin
         mag_rnd_s = POSIT8_MAXPOS;
      end else if (sum_s[6:0] == 7'h00) begin
         mag_rnd_s = POSIT8_MINPOS;
      end else begin
         mag_rnd_s = sum_s[6:0];
      end
      if (s1_nar_r) begin
         posit_s = POSIT8_NAR;
      end else if (s1_zero_r) begin
         posit_s = POSIT8_ZERO;
      end else begin
         posit_s = posit8_apply_sign(s1_sign_r, mag_rnd_s);
      end
   end

   // Stage 2 register: the packed result, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_posit_r <= POSIT8_ZERO;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_posit_r <= posit_s;
         end
      end
   end

endmodule

// File: tb/tb_posit8_regime_encoder.sv
// Self-checking bench for posit8_regime_encoder. The reference model decodes
// every positive posit8 pattern to an exact scaled value and picks the nearest
// one to the exact input value (ties to the even pattern).
module tb_posit8_regime_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   posit8_regime_encoder_if bus();

   posit8_regime_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     checks = 0;
   int     errors = 0;
   longint pval [0:127];

   // Exact value of a positive posit pattern in units of 2^-13.
   function automatic longint decode_val(input int p);
      int r0, n, k, fb, f;
      bit run;
      r0  = (p >> 6) & 1;
      n   = 1;
      run = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         if (run && (((p >> i) & 1) == r0)) n++;
         else run = 1'b0;
      end
      k  = (r0 == 1) ? (n - 1) : -n;
      fb = 7 - n - 1;
      if (fb < 0) fb = 0;
      f = p & ((1 << fb) - 1);
      return longint'((1 << fb) + f) << (k + 13 - fb);
   endfunction

   function automatic logic [7:0] ref_encode(input logic s, input logic z, input logic n,
                                             input logic [3:0] e, input logic [4:0] f,
                                             input logic g, input logic st);
      longint v, d, bestd;
      int k, best;
      if (n) return 8'h80;
      if (z) return 8'h00;
      best = 127;
      if (e <= 4'd12) begin
         k = int'(e) - 6;
         // significand in 1/128ths: hidden 1, 5 frac bits, guard, sticky as a half-step
         v = longint'((64 + 2 * int'(f) + int'(g)) * 2 + int'(st)) << (k + 6);
         best  = 1;
         bestd = (v > pval[1]) ? v - pval[1] : pval[1] - v;
         for (int p = 2; p < 128; p++) begin
            d = (v > pval[p]) ? v - pval[p] : pval[p] - v;
            if (d < bestd || (d == bestd && (p % 2) == 0)) begin
               best  = p;
               bestd = d;
            end
         end
      end
      return s ? 8'((256 - best) & 255) : 8'(best);
   endfunction

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.sign_in   = 1'b0;
      bus.zero_in   = 1'b0;
      bus.nar_in    = 1'b0;
      bus.exp_in    = 4'd0;
      bus.frac_in   = 5'd0;
      bus.guard_in  = 1'b0;
      bus.sticky_in = 1'b0;
   endtask

   task automatic rand_fields();
      bus.sign_in   = 1'($urandom_range(0, 1));
      bus.nar_in    = ($urandom_range(0, 15) == 0);
      bus.zero_in   = ($urandom_range(0, 15) == 0);
      bus.exp_in    = 4'($urandom_range(0, 15));
      bus.frac_in   = 5'($urandom_range(0, 31));
      bus.guard_in  = 1'($urandom_range(0, 1));
      bus.sticky_in = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
      end
      checks++;
      if (bus.posit_out !== 8'h00) begin
         errors++; $display("FAIL reset_posit got %02h want 00", bus.posit_out);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release_valid got %0b want 0", bus.out_valid);
      end
   endtask

   task automatic test_directed();
      logic       ds [16] = '{0,1,0,0,0,0,0,0,0,1,0,0,1,0,0,0};
      logic       dz [16] = '{0,0,0,0,0,0,0,0,1,1,0,0,0,0,0,0};
      logic       dn [16] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0};
      logic [3:0] de [16] = '{4'd6,4'd6,4'd7,4'd12,4'd14,4'd11,4'd11,4'd0,
                              4'd3,4'd9,4'd0,4'd1,4'd12,4'd8,4'd6,4'd6};
      logic [4:0] df [16] = '{5'b00000,5'b00000,5'b10000,5'b10110,5'b00101,5'b10000,5'b10001,5'b11000,
                              5'b01010,5'b00000,5'b00000,5'b10000,5'b00000,5'b11111,5'b00001,5'b00000};
      logic       dg [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1};
      logic [7:0] dr [16] = '{8'h40,8'hC0,8'h68,8'h7F,8'h7F,8'h7E,8'h7F,8'h02,
                              8'h80,8'h00,8'h01,8'h03,8'h81,8'h78,8'h42,8'h40};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.sign_in   = ds[i];
         bus.zero_in   = dz[i];
         bus.nar_in    = dn[i];
         bus.exp_in    = de[i];
         bus.frac_in   = df[i];
         bus.guard_in  = dg[i];
         bus.sticky_in = 1'b0;
         @(negedge clk);
         idle_inputs();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL dir[%0d]_early_valid got %0b want 0", i, bus.out_valid);
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.posit_out !== dr[i]) begin
            errors++;
            $display("FAIL dir[%0d] got valid=%0b posit=%02h want valid=1 posit=%02h",
                     i, bus.out_valid, bus.posit_out, dr[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] held = 8'h00;
      logic [7:0] expv;
      bit stalled = 1'b0;
      int sent = 0, got = 0, cyc = 0;
      while (got < 300 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.posit_out !== held) begin
               errors++;
               $display("FAIL rand_hold got valid=%0b posit=%02h want valid=1 posit=%02h",
                        bus.out_valid, bus.posit_out, held);
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 300 && $urandom_range(0, 3) != 0) begin
            bus.in_valid = 1'b1;
            rand_fields();
         end else begin
            idle_inputs();
         end
         #1;
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_extra got %02h want no output", bus.posit_out);
            end else begin
               expv = q.pop_front();
               if (bus.posit_out !== expv) begin
                  errors++; $display("FAIL rand[%0d] got %02h want %02h", got, bus.posit_out, expv);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_encode(bus.sign_in, bus.zero_in, bus.nar_in, bus.exp_in,
                                   bus.frac_in, bus.guard_in, bus.sticky_in));
            sent++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = bus.posit_out;
      end
      checks++;
      if (got < 300) begin
         errors++; $display("FAIL rand_timeout got %0d results want 300", got);
      end
      @(negedge clk);
      idle_inputs();
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      logic [7:0] held = 8'h00;
      logic [7:0] expv;
      bit stalled = 1'b0;
      int sent = 0, got = 0, cyc = 0;
      while (got < 8 && cyc < 60) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.posit_out !== held) begin
               errors++;
               $display("FAIL b2b_hold got valid=%0b posit=%02h want valid=1 posit=%02h",
                        bus.out_valid, bus.posit_out, held);
            end
         end
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         if (sent < 8) begin
            bus.in_valid = 1'b1;
            rand_fields();
         end else begin
            idle_inputs();
         end
         #1;
         if (cyc >= 4 && cyc <= 6) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++; $display("FAIL b2b_in_ready cyc=%0d got %0b want 0", cyc, bus.in_ready);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got %02h want no output", bus.posit_out);
            end else begin
               expv = q.pop_front();
               if (bus.posit_out !== expv) begin
                  errors++; $display("FAIL b2b[%0d] got %02h want %02h", got, bus.posit_out, expv);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_encode(bus.sign_in, bus.zero_in, bus.nar_in, bus.exp_in,
                                   bus.frac_in, bus.guard_in, bus.sticky_in));
            sent++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = bus.posit_out;
         cyc++;
      end
      checks++;
      if (got < 8) begin
         errors++; $display("FAIL b2b_timeout got %0d results want 8", got);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         bus.out_ready = 1'b1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_duplicate got valid=%0b want 0", bus.out_valid);
         end
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         rand_fields();
         bus.nar_in   = 1'b0;
         bus.zero_in  = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_full got valid=%0b in_ready=%0b want valid=1 in_ready=0",
                  bus.out_valid, bus.in_ready);
      end
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.posit_out !== 8'h00) begin
         errors++;
         $display("FAIL midrst_clear got valid=%0b posit=%02h want valid=0 posit=00",
                  bus.out_valid, bus.posit_out);
      end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_stale got valid=%0b posit=%02h want valid=0",
                               bus.out_valid, bus.posit_out);
         end
      end
      bus.in_valid = 1'b1;
      bus.exp_in   = 4'd6;
      bus.frac_in  = 5'd0;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.posit_out !== 8'h40) begin
         errors++;
         $display("FAIL midrst_recover got valid=%0b posit=%02h want valid=1 posit=40",
                  bus.out_valid, bus.posit_out);
      end
   endtask

   initial begin
      for (int p = 0; p < 128; p++) pval[p] = (p == 0) ? 64'sd0 : decode_val(p);
      bus.out_ready = 1'b1;
      idle_inputs();
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
